// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave register file.
// Holds the slave FSM state encoding and bus constants.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      IGNORE
   } state_t;

   localparam logic I2C_ACK = 1'b0;

endpackage

// File: rtl/i2c_bus_monitor.sv
// I2C bus condition detector: samples SCL/SDA each clk and
// flags SCL rise, START, STOP and SCL held high across two samples.
module i2c_bus_monitor (
   input  logic clk,
   input  logic reset,
   input  logic scl,
   input  logic sda,
   output logic rise,
   output logic start,
   output logic stop,
   output logic hold
);

   logic scl_q;
   logic sda_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl;
         sda_q <= sda;
      end
   end

   assign rise  = !scl_q & scl;
   assign start = scl_q & scl & sda_q & !sda;
   assign stop  = scl_q & scl & !sda_q & sda;
   assign hold  = scl_q & scl;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave with a byte register file: first written byte sets the
// pointer, later bytes write with auto-increment; reads stream from it.
module i2c_slave_regfile
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int MEM_DEPTH = 16,
   localparam int PTR_W = $clog2(MEM_DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             SCL,
   inout  wire              SDA,
   output logic             wr_en,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   output logic             busy,
   input  logic [PTR_W-1:0] dbg_addr,
   output logic [7:0]       dbg_data
);

   state_t           state;
   logic             sda_oe;
   logic [7:0]       sreg;
   logic [2:0]       bitcnt;
   logic [PTR_W-1:0] ptr;
   logic             ptr_loaded;
   logic             rw;
   logic [7:0]       mem [MEM_DEPTH];

   logic       rise;
   logic       start;
   logic       stop;
   logic       hold;
   logic [7:0] shifted;

   i2c_bus_monitor u_mon (
      .clk   (clk),
      .reset (reset),
      .scl   (SCL),
      .sda   (SDA),
      .rise  (rise),
      .start (start),
      .stop  (stop),
      .hold  (hold)
   );

   assign SDA      = sda_oe ? 1'b0 : 1'bz;
   assign shifted  = {sreg[6:0], SDA};
   assign busy     = !(state == IDLE || state == IGNORE);
   assign dbg_data = mem[dbg_addr];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         sda_oe     <= 1'b0;
         sreg       <= 8'h00;
         bitcnt     <= 3'd0;
         ptr        <= '0;
         ptr_loaded <= 1'b0;
         rw         <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 8'h00;
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
      end else begin
         wr_en <= 1'b0;
         if (start) begin
            state  <= ADDR;
            bitcnt <= 3'd0;
            sda_oe <= 1'b0;
         end else if (stop) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
         end else begin
            unique case (state)
               IDLE, IGNORE: sda_oe <= 1'b0;
               ADDR: if (rise) begin
                  sreg   <= shifted;
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) begin
                     if (shifted[7:1] == SLAVE_ADDR) begin
                        sda_oe     <= 1'b1;
                        rw         <= shifted[0];
                        ptr_loaded <= 1'b0;
                        state      <= ADDR_ACK;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               ADDR_ACK: if (rise) begin
                  bitcnt <= 3'd0;
                  if (!rw) begin
                     sda_oe <= 1'b0;
                     state  <= WR_DATA;
                  end else begin
                     sreg   <= mem[ptr];
                     sda_oe <= ~mem[ptr][7];
                     state  <= RD_DATA;
                  end
               end
               WR_DATA: if (rise) begin
                  sreg   <= shifted;
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) begin
                     sda_oe <= 1'b1;
                     state  <= WR_ACK;
                     if (!ptr_loaded) begin
                        ptr        <= shifted[PTR_W-1:0];
                        ptr_loaded <= 1'b1;
                     end else begin
                        mem[ptr] <= shifted;
                        wr_en    <= 1'b1;
                        wr_addr  <= ptr;
                        wr_data  <= shifted;
                        ptr      <= ptr + PTR_W'(1);
                     end
                  end
               end
               WR_ACK: if (rise) begin
                  sda_oe <= 1'b0;
                  bitcnt <= 3'd0;
                  state  <= WR_DATA;
               end
               // SCL held high here means the master is heading for STOP.
               RD_DATA: if (hold) begin
                  sda_oe <= 1'b0;
                  state  <= IGNORE;
               end else if (rise) begin
                  bitcnt <= bitcnt + 3'd1;
                  sreg   <= sreg << 1;
                  if (bitcnt == 3'd7) begin
                     sda_oe <= 1'b0;
                     ptr    <= ptr + PTR_W'(1);
                     state  <= RD_ACK;
                  end else begin
                     sda_oe <= ~sreg[6];
                  end
               end
               RD_ACK: if (rise) begin
                  if (SDA == I2C_ACK) begin
                     sreg   <= mem[ptr];
                     sda_oe <= ~mem[ptr][7];
                     bitcnt <= 3'd0;
                     state  <= RD_DATA;
                  end else begin
                     state <= IGNORE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged master, directed table,
// reset-abort sequence and random transactions against a byte model.
module tb_i2c_slave_regfile;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl = 1'b1;
   logic       m_low = 1'b0;
   wire        sda;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic [3:0] dbg_addr = 4'h0;
   logic [7:0] dbg_data;

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_slave_regfile dut (
      .clk      (clk),
      .reset    (reset),
      .SCL      (scl),
      .SDA      (sda),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0]  mm [16];
   logic [3:0]  mp;
   logic [11:0] exp_wr [$];
   logic [11:0] got_wr [$];

   always @(negedge clk) if (wr_en === 1'b1) got_wr.push_back({wr_addr, wr_data});

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Reference model: pointer/auto-increment semantics per transaction.
   function automatic void model_xfer(input logic [6:0] a, input logic rw, input int n,
                                      input logic [0:3][7:0] d, output logic ea,
                                      output logic [0:3][7:0] er);
      er = '0;
      ea = (a == 7'h50);
      if (!ea) return;
      for (int i = 0; i < n; i++) begin
         if (!rw) begin
            if (i == 0) mp = d[0][3:0];
            else begin
               mm[mp] = d[i];
               exp_wr.push_back({mp, d[i]});
               mp = mp + 4'd1;
            end
         end else begin
            er[i] = mm[mp];
            mp = mp + 4'd1;
         end
      end
   endfunction

   task automatic bit_io(input logic b, output logic s);
      @(negedge clk);
      scl = 1'b0;
      m_low = !b;
      @(negedge clk);
      scl = 1'b1;
      s = sda;
   endtask

   task automatic do_start();
      @(negedge clk);
      scl = 1'b1;
      m_low = 1'b0;
      @(negedge clk);
      m_low = 1'b1;
   endtask

   task automatic do_stop();
      @(negedge clk);
      scl = 1'b0;
      m_low = 1'b1;
      @(negedge clk);
      scl = 1'b1;
      @(negedge clk);
      m_low = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle_exit();
      @(negedge clk);
      scl = 1'b0;
      m_low = 1'b0;
      @(negedge clk);
      scl = 1'b1;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_io(b[i], s);
      bit_io(1'b1, s);
      ack = !s;
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_io(1'b1, s);
         b[i] = s;
      end
      bit_io(nack, s);
   endtask

   task automatic xfer(input logic [6:0] a, input logic rw, input int n,
                       input logic [0:3][7:0] d, output logic aack,
                       output logic [3:0] acks, output logic [0:3][7:0] rd);
      logic k;
      acks = '0;
      rd = '0;
      do_start();
      send_byte({a, rw}, aack);
      if (!aack) begin
         idle_exit();
         return;
      end
      for (int i = 0; i < n; i++) begin
         if (!rw) begin
            send_byte(d[i], k);
            acks[i] = k;
         end else begin
            recv_byte(i == n - 1, rd[i]);
         end
      end
      do_stop();
   endtask

   task automatic check_after(input string tag);
      logic bad;
      @(negedge clk);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_wr_count"}, got_wr.size(), exp_wr.size());
      while (got_wr.size() > 0 && exp_wr.size() > 0)
         chk({tag, "_wr_pulse"}, 32'(got_wr.pop_front()), 32'(exp_wr.pop_front()));
      got_wr.delete();
      exp_wr.delete();
      bad = 1'b0;
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         #1;
         if (dbg_data !== mm[i]) begin
            bad = 1'b1;
            $display("FAIL %s_mem[%0d] got=%0h expected=%0h", tag, i, dbg_data, mm[i]);
         end
      end
      checks++;
      if (bad) errors++;
   endtask

   typedef struct {
      logic [6:0]      addr;
      logic            rw;
      int              n;
      logic [0:3][7:0] d;
      logic            exp_ack;
      logic [0:3][7:0] exp_rd;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic            aa, ea;
      logic [3:0]      acks;
      logic [0:3][7:0] rd, er, d;
      logic [6:0]      a;
      logic            rw, s;
      int              n, kind;

      tbl[0] = '{7'h50, 1'b0, 3, {8'h03, 8'hA5, 8'h3C, 8'h00}, 1'b1, '0};
      tbl[1] = '{7'h50, 1'b0, 1, {8'h03, 8'h00, 8'h00, 8'h00}, 1'b1, '0};
      tbl[2] = '{7'h50, 1'b1, 2, '0, 1'b1, {8'hA5, 8'h3C, 8'h00, 8'h00}};
      tbl[3] = '{7'h51, 1'b0, 1, {8'h07, 8'h00, 8'h00, 8'h00}, 1'b0, '0};
      tbl[4] = '{7'h50, 1'b0, 3, {8'h0F, 8'h11, 8'h22, 8'h00}, 1'b1, '0};
      tbl[5] = '{7'h50, 1'b0, 2, {8'hF2, 8'h77, 8'h00, 8'h00}, 1'b1, '0};
      tbl[6] = '{7'h50, 1'b0, 1, {8'h0F, 8'h00, 8'h00, 8'h00}, 1'b1, '0};
      tbl[7] = '{7'h50, 1'b1, 2, '0, 1'b1, {8'h11, 8'h22, 8'h00, 8'h00}};

      for (int i = 0; i < 16; i++) mm[i] = 8'h00;
      mp = 4'h0;

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_sda", 32'(sda), 32'd1);
      reset = 1'b0;
      check_after("rst");

      foreach (tbl[r]) begin
         model_xfer(tbl[r].addr, tbl[r].rw, tbl[r].n, tbl[r].d, ea, er);
         xfer(tbl[r].addr, tbl[r].rw, tbl[r].n, tbl[r].d, aa, acks, rd);
         chk($sformatf("tbl%0d_addr_ack", r), 32'(aa), 32'(tbl[r].exp_ack));
         if (tbl[r].exp_ack && !tbl[r].rw)
            chk($sformatf("tbl%0d_data_acks", r), 32'(acks), (32'd1 << tbl[r].n) - 1);
         if (tbl[r].rw)
            for (int i = 0; i < tbl[r].n; i++)
               chk($sformatf("tbl%0d_rd%0d", r, i), 32'(rd[i]), 32'(tbl[r].exp_rd[i]));
         check_after($sformatf("tbl%0d", r));
      end

      // Reset while the master shifts the 4th bit of a data byte.
      do_start();
      send_byte({7'h50, 1'b0}, aa);
      chk("rst5_addr_ack", 32'(aa), 32'd1);
      send_byte(8'h05, aa);
      for (int i = 7; i > 4; i--) bit_io(1'b0, s);
      @(negedge clk);
      scl = 1'b0;
      m_low = 1'b0;
      @(negedge clk);
      scl = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      chk("rst5_sda", 32'(sda), 32'd1);
      chk("rst5_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) mm[i] = 8'h00;
      mp = 4'h0;
      check_after("rst5");
      d = {8'h06, 8'h99, 8'h00, 8'h00};
      model_xfer(7'h50, 1'b0, 2, d, ea, er);
      xfer(7'h50, 1'b0, 2, d, aa, acks, rd);
      chk("rst5_after_ack", 32'(aa), 32'd1);
      chk("rst5_after_acks", 32'(acks), 32'h3);
      check_after("rst5_after");

      for (int t = 0; t < 30; t++) begin
         kind = $urandom_range(0, 9);
         a = 7'h50;
         rw = (kind >= 5);
         if (kind >= 8) begin
            a = 7'h50 ^ 7'(1 << $urandom_range(0, 6));
            rw = 1'($urandom_range(0, 1));
         end
         n = rw ? $urandom_range(1, 3) : $urandom_range(1, 4);
         for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
         model_xfer(a, rw, n, d, ea, er);
         xfer(a, rw, n, d, aa, acks, rd);
         chk($sformatf("rnd%0d_addr_ack", t), 32'(aa), 32'(ea));
         if (ea && !rw)
            chk($sformatf("rnd%0d_data_acks", t), 32'(acks), (32'd1 << n) - 1);
         if (ea && rw)
            for (int i = 0; i < n; i++)
               chk($sformatf("rnd%0d_rd%0d", t, i), 32'(rd[i]), 32'(er[i]));
         check_after($sformatf("rnd%0d", t));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
